// File: rtl/bicubic_interp_1d.sv
// bicubic_interp_1d: multi-cycle Catmull-Rom 1-D interpolator; define BICUBIC_SAT_EN to clamp the result to the pixel range
module bicubic_interp_1d #(
    parameter int PIX_W  = 8,
    parameter int FRAC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  p_m1,
    input  logic [PIX_W-1:0]  p_0,
    input  logic [PIX_W-1:0]  p_1,
    input  logic [PIX_W-1:0]  p_2,
    input  logic [FRAC_W-1:0] frac,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_pix,
    output logic              busy
);
    localparam int WW = FRAC_W + 5;
    localparam int AW = PIX_W + FRAC_W + 7;
    localparam int MW = 2 * FRAC_W;
    localparam logic signed [WW-1:0] T0 = {4'b0, 1'b1, {FRAC_W{1'b0}}};
    localparam logic [MW-1:0] HALF = {{(FRAC_W+1){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic signed [AW-1:0] RND = {{(AW-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
    localparam logic signed [AW-1:0] PMAX = {{(AW-PIX_W){1'b0}}, {PIX_W{1'b1}}};

    typedef enum logic [2:0] {S_IDLE, S_SQ, S_CU, S_M0, S_M1, S_M2, S_M3, S_OUT} state_t;

    state_t                   r_state, w_next;
    logic [PIX_W-1:0]         r_pm1, r_p0, r_p1, r_p2, r_out_pix;
    logic [FRAC_W-1:0]        r_frac, r_t2, r_t3;
    logic signed [AW-1:0]     r_acc;
    logic                     r_out_valid;
    logic [FRAC_W-1:0]        w_ma;
    logic [MW-1:0]            w_mp;
    logic signed [WW-1:0]     w_t1, w_t2, w_t3, w_c0, w_c1, w_c2, w_c3, w_w;
    logic [PIX_W-1:0]         w_px;
    logic signed [AW-1:0]     w_prod, w_sum, w_rnd, w_res;
    logic [PIX_W-1:0]         w_pix_nxt;

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = !in_ready;
    assign out_valid = r_out_valid;
    assign out_pix   = r_out_pix;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = in_valid ? S_SQ : S_IDLE;
            S_SQ:    w_next = S_CU;
            S_CU:    w_next = S_M0;
            S_M0:    w_next = S_M1;
            S_M1:    w_next = S_M2;
            S_M2:    w_next = S_M3;
            S_M3:    w_next = S_OUT;
            default: w_next = out_ready ? S_IDLE : S_OUT;
        endcase
    end

    // One shared multiplier produces t^2 in SQ and t^3 in CU
    assign w_ma = (r_state == S_SQ) ? r_frac : r_t2;
    assign w_mp = MW'(w_ma) * MW'(r_frac) + HALF;

    assign w_t1 = {5'b0, r_frac};
    assign w_t2 = {5'b0, r_t2};
    assign w_t3 = {5'b0, r_t3};
    assign w_c0 = (w_t2 <<< 1) - w_t1 - w_t3;
    assign w_c1 = (T0 <<< 1) - (w_t2 <<< 2) - w_t2 + (w_t3 <<< 1) + w_t3;
    assign w_c2 = w_t1 + (w_t2 <<< 2) - (w_t3 <<< 1) - w_t3;
    assign w_c3 = w_t3 - w_t2;

    assign w_w  = (r_state == S_M0) ? w_c0 : (r_state == S_M1) ? w_c1 : (r_state == S_M2) ? w_c2 : w_c3;
    assign w_px = (r_state == S_M0) ? r_pm1 : (r_state == S_M1) ? r_p0 : (r_state == S_M2) ? r_p1 : r_p2;

    assign w_prod = AW'(w_w) * AW'($signed({1'b0, w_px}));
    assign w_sum  = r_acc + w_prod;
    assign w_rnd  = w_sum + RND;
    assign w_res  = w_rnd >>> (FRAC_W + 1);

`ifdef BICUBIC_SAT_EN
    assign w_pix_nxt = (w_res < 0) ? '0 : (w_res > PMAX) ? '1 : w_res[PIX_W-1:0];
`else
    assign w_pix_nxt = w_res[PIX_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pm1       <= '0;
            r_p0        <= '0;
            r_p1        <= '0;
            r_p2        <= '0;
            r_frac      <= '0;
            r_t2        <= '0;
            r_t3        <= '0;
            r_acc       <= '0;
            r_out_pix   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_state == S_IDLE && in_valid) begin
                r_pm1  <= p_m1;
                r_p0   <= p_0;
                r_p1   <= p_1;
                r_p2   <= p_2;
                r_frac <= frac;
                r_acc  <= '0;
            end
            if (r_state == S_SQ) r_t2 <= w_mp[MW-1:FRAC_W];
            if (r_state == S_CU) r_t3 <= w_mp[MW-1:FRAC_W];
            if (r_state == S_M0 || r_state == S_M1 || r_state == S_M2 || r_state == S_M3) r_acc <= w_sum;
            if (r_state == S_M3) begin
                r_out_pix   <= w_pix_nxt;
                r_out_valid <= 1'b1;
            end
            if (r_state == S_OUT && out_ready) r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_bicubic_interp_1d.sv
// tb_bicubic_interp_1d: directed vectors with hand-computed results for bicubic_interp_1d
module tb_bicubic_interp_1d;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] p_m1 = '0, p_0 = '0, p_1 = '0, p_2 = '0;
    logic [7:0] frac = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_pix;
    logic       busy;
    int         tests = 0;
    int         fails = 0;

    bicubic_interp_1d dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .p_m1(p_m1), .p_0(p_0), .p_1(p_1), .p_2(p_2), .frac(frac),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic [7:0] a, b, c, d, f, exp, input int stall, input string tag);
        int n;
        logic [7:0] held;
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        p_m1 = a; p_0 = b; p_1 = c; p_2 = d; frac = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        p_m1 = ~a; p_0 = ~b; p_1 = ~c; p_2 = ~d; frac = ~f;
        chk({tag, "_busy"}, busy, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, n, 6);
        chk({tag, "_pix"}, out_pix, exp);
        held = out_pix;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk({tag, "_stall_pix"}, out_pix, held);
            chk({tag, "_stall_valid"}, out_valid, 1);
            chk({tag, "_stall_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk({tag, "_released"}, out_valid, 0);
        chk({tag, "_idle"}, in_ready, 1);
        chk({tag, "_pix_kept"}, out_pix, held);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pix", out_pix, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("stray_ready_valid", out_valid, 0);

        txn(8'd46, 8'd47, 8'd46, 8'd12, 8'd0,   8'd47,  0, "f0");
        txn(8'd46, 8'd47, 8'd46, 8'd12, 8'd128, 8'd49,  0, "f128");
        txn(8'd0,  8'd0,  8'd255, 8'd255, 8'd128, 8'd128, 0, "step");
`ifdef BICUBIC_SAT_EN
        txn(8'd0,   8'd255, 8'd255, 8'd0,   8'd128, 8'd255, 0, "over");
        txn(8'd255, 8'd0,   8'd0,   8'd255, 8'd128, 8'd0,   0, "under");
`else
        txn(8'd0,   8'd255, 8'd255, 8'd0,   8'd128, 8'd31,  0, "over");
        txn(8'd255, 8'd0,   8'd0,   8'd255, 8'd128, 8'd224, 0, "under");
`endif
        txn(8'd10,  8'd20,  8'd30,  8'd40,  8'd64,  8'd23,  0, "f64");
        txn(8'd100, 8'd100, 8'd100, 8'd100, 8'd255, 8'd100, 0, "flat");
        txn(8'd0,   8'd0,   8'd200, 8'd0,   8'd255, 8'd200, 0, "f255");
        txn(8'd46,  8'd47,  8'd46,  8'd12,  8'd128, 8'd49,  10, "stall");

        @(negedge clk);
        in_valid = 1'b1;
        p_m1 = 8'd0; p_0 = 8'd255; p_1 = 8'd255; p_2 = 8'd0; frac = 8'd128;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_pix", out_pix, 0);
        begin
            int spurious = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                if (out_valid) spurious++;
            end
            chk("abort_no_output", spurious, 0);
        end
        txn(8'd10, 8'd20, 8'd30, 8'd40, 8'd64, 8'd23, 0, "recover");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
